// File: rtl/hqm_rcfwl_gclk_qdivctl_pkg.sv
// Shared types and helpers for the quarter-rate divider ratio-change sequencer.
package hqm_rcfwl_gclk_qdivctl_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    INIT_RST,
    IDLE,
    WAIT_BOUND,
    GATE,
    RST,
    SETTLE,
    ACK
  } qdiv_state_e;

  function automatic logic ratio_legal(input logic [3:0] ratio,
                                       input int unsigned lo,
                                       input int unsigned hi);
    int unsigned r;
    r = 32'(ratio);
    return (r >= lo) && (r <= hi);
  endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_qdivctl_tmr.sv
// Loadable down counter shared by every timed sequencer state; done while zero.
module hqm_rcfwl_gclk_qdivctl_tmr
  import hqm_rcfwl_gclk_qdivctl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clkin,
  input  logic             rb,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Reset preloads the INIT_RST hold so bring-up gets its full divider-reset time.
  always_ff @(posedge clkin or negedge rb) begin
    if (!rb) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hqm_rcfwl_gclk_iclk_qdivctl.sv
// Ratio-change sequencer: waits for a divider period boundary, gates the clock,
// resets and reloads the divider, settles, then re-enables the clock.
module hqm_rcfwl_gclk_iclk_qdivctl
  import hqm_rcfwl_gclk_qdivctl_pkg::*;
#(
  parameter logic [3:0]  RESET_RATIO = 4'd4,
  parameter int unsigned RATIO_MIN   = 2,
  parameter int unsigned RATIO_MAX   = 15,
  parameter int unsigned GATE_CYC    = 2,
  parameter int unsigned RST_CYC     = 2,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned BOUND_TO    = 31
) (
  input  logic       clkin,
  input  logic       rb,
  input  logic       ratio_req_vld,
  input  logic [3:0] ratio_req,
  input  logic       dutycyc_50p_req,
  input  logic       hith,
  output logic       ratio_req_ack,
  output logic       ratio_err,
  output logic       ratio_busy,
  output logic       divrstb,
  output logic [3:0] ratiom3,
  output logic       dutycyc_50p_en,
  output logic       clkgate_en
);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BOUND_LD  = CNT_W'(BOUND_TO - 1);

  qdiv_state_e      state, state_nxt;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [3:0]       pend_ratio;
  logic             pend_dc, req_active, ack_prev, hith_q;
  logic             req_legal, req_same;

  assign req_legal = ratio_legal(ratio_req, RATIO_MIN, RATIO_MAX);
  assign req_same  = (ratio_req == ratiom3) && (dutycyc_50p_req == dutycyc_50p_en);

  hqm_rcfwl_gclk_qdivctl_tmr #(.RST_VAL(RST_LD)) u_tmr (
    .clkin    (clkin),
    .rb       (rb),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      INIT_RST: if (tmr_done) begin
        state_nxt = SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = SETTLE_LD;
      end
      // ack_prev blocks re-accepting a request still held over from the last ack.
      IDLE: if (ratio_req_vld && !ack_prev) begin
        if (!req_legal || req_same) begin
          state_nxt = ACK;
        end else begin
          state_nxt = WAIT_BOUND;
          tmr_load  = 1'b1;
          tmr_val   = BOUND_LD;
        end
      end
      WAIT_BOUND: if ((hith && !hith_q) || tmr_done) begin
        state_nxt = GATE;
        tmr_load  = 1'b1;
        tmr_val   = GATE_LD;
      end
      GATE: if (tmr_done) begin
        state_nxt = RST;
        tmr_load  = 1'b1;
        tmr_val   = RST_LD;
      end
      RST: if (tmr_done) begin
        state_nxt = SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = SETTLE_LD;
      end
      SETTLE: if (tmr_done) state_nxt = req_active ? ACK : IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = INIT_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clkin or negedge rb) begin
    if (!rb) begin
      state          <= INIT_RST;
      divrstb        <= 1'b0;
      ratiom3        <= RESET_RATIO;
      dutycyc_50p_en <= 1'b0;
      clkgate_en     <= 1'b0;
      ratio_req_ack  <= 1'b0;
      ratio_err      <= 1'b0;
      ratio_busy     <= 1'b1;
      hith_q         <= 1'b0;
      ack_prev       <= 1'b0;
      pend_ratio     <= RESET_RATIO;
      pend_dc        <= 1'b0;
      req_active     <= 1'b0;
    end else begin
      state         <= state_nxt;
      hith_q        <= hith;
      ack_prev      <= ratio_req_ack;
      ratio_busy    <= (state_nxt != IDLE);
      ratio_req_ack <= (state_nxt == ACK);
      ratio_err     <= (state == IDLE) && (state_nxt == ACK) && !req_legal;
      if (state_nxt != state) begin
        case (state_nxt)
          WAIT_BOUND: begin
            pend_ratio <= ratio_req;
            pend_dc    <= dutycyc_50p_req;
            req_active <= 1'b1;
          end
          GATE: clkgate_en <= 1'b0;
          // New ratio lands together with divider reset so it never runs on a live clock.
          RST: begin
            divrstb        <= 1'b0;
            ratiom3        <= pend_ratio;
            dutycyc_50p_en <= pend_dc;
          end
          SETTLE: begin
            divrstb    <= 1'b1;
            clkgate_en <= 1'b0;
          end
          ACK: begin
            clkgate_en <= 1'b1;
            req_active <= 1'b0;
          end
          IDLE: begin
            clkgate_en <= 1'b1;
            divrstb    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
